// File: rtl/data_tx_pkg.sv
// -----------------------------------------------------------------------------
// data_tx_pkg
// Shared types and sizes for the data_stream_tx return-path sequencer.
//   tx_state_t  : sequencer states (4-bit encoding)
//   OFS_W       : byte offset width inside a block
//   BLK_W       : block address width
//   ADDR_W      : memory address width {block, offset}
//   CNT_W       : byte counter width (holds 1..65)
//   byte_count(): total data bytes for an inclusive, wrapping offset range
// -----------------------------------------------------------------------------
package data_tx_pkg;

   localparam int OFS_W  = 6;
   localparam int BLK_W  = 10;
   localparam int ADDR_W = BLK_W + OFS_W;
   localparam int CNT_W  = OFS_W + 1;
   localparam int DATA_W = 8;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      ISSUE = 4'd1,
      WAIT  = 4'd2,
      SEND  = 4'd3,
      CSUM  = 4'd4,
      DONE  = 4'd5
   } tx_state_t;

   // The offset difference is taken modulo 2**OFS_W, so end < start wraps
   // through the top of the block and start == end yields a single byte.
   function automatic logic [CNT_W-1:0] byte_count(input logic [OFS_W-1:0] start_ofs,
                                                   input logic [OFS_W-1:0] end_ofs);
      logic [OFS_W-1:0] span;
      span = end_ofs - start_ofs;
      return {1'b0, span} + 1'b1;
   endfunction

endpackage

// File: rtl/data_stream_tx_if.sv
// -----------------------------------------------------------------------------
// data_stream_tx_if
// Memory read port plus transmitter valid/ready channel of data_stream_tx.
//   mem_read  : one-cycle read strobe            (master -> slave)
//   mem_addr  : {block, offset} read address     (master -> slave)
//   mem_rdata : read data, fixed latency later   (slave  -> master)
//   tx_data   : byte offered to the transmitter  (master -> slave)
//   tx_valid  : tx_data is valid                 (master -> slave)
//   tx_ready  : transmitter accepts this cycle   (slave  -> master)
// -----------------------------------------------------------------------------
interface data_stream_tx_if;
   import data_tx_pkg::*;

   logic              mem_read;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output mem_read, mem_addr, tx_data, tx_valid,
      input  mem_rdata, tx_ready
   );

   modport slave (
      input  mem_read, mem_addr, tx_data, tx_valid,
      output mem_rdata, tx_ready
   );

endinterface

// File: rtl/rd_latency_timer.sv
// -----------------------------------------------------------------------------
// rd_latency_timer
// Loadable down-counter that spaces the memory read strobe from the cycle in
// which the read data is valid.
//   clk, n_reset : clock / asynchronous active-low reset
//   load         : high during the read-strobe cycle; reloads the counter
//   expire       : high in the last wait cycle, i.e. the cycle mem_rdata is valid
// Loading MEM_LATENCY-1 gives exactly MEM_LATENCY wait cycles after the
// strobe, the last one flagged by expire.
// -----------------------------------------------------------------------------
module rd_latency_timer #(
   parameter int MEM_LATENCY = 2
)(
   input  logic clk,
   input  logic n_reset,
   input  logic load,
   output logic expire
);

   localparam int TW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [TW-1:0] LOAD_VAL = TW'(MEM_LATENCY - 1);

   logic [TW-1:0] count_reg;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= LOAD_VAL;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign expire = (count_reg == '0);

endmodule

// File: rtl/data_stream_tx.sv
// -----------------------------------------------------------------------------
// data_stream_tx
// Return-path sequencer: reads bytes start..end (inclusive, wrapping at the
// block boundary) from block_address and streams them to the USB transmitter
// over a valid/ready handshake, then pulses Done for one cycle.
//
// Ports
//   clk           : system clock
//   n_reset       : asynchronous active-low reset
//   StartEnable   : launch request, honoured in IDLE only
//   Abort         : synchronous cancel, overrides every other input
//   start_address : first byte offset
//   end_address   : last byte offset (inclusive)
//   block_address : block select
//   bus           : data_stream_tx_if.master (memory read + transmitter channel)
//   Done          : one-cycle completion pulse
//   busy          : high whenever the sequencer is not idle
//   bytes_left    : bytes not yet accepted by the transmitter
//
// Build option
//   DATA_TX_CHECKSUM_EN : append the XOR of all data bytes as one extra byte
//                         (CSUM state) before Done; bytes_left counts it.
//
// Parameter
//   MEM_LATENCY : cycles from the mem_read cycle to the mem_rdata-valid cycle (1..15)
// -----------------------------------------------------------------------------
module data_stream_tx
   import data_tx_pkg::*;
#(
   parameter int MEM_LATENCY = 2
)(
   input  logic               clk,
   input  logic               n_reset,
   input  logic               StartEnable,
   input  logic               Abort,
   input  logic [OFS_W-1:0]   start_address,
   input  logic [OFS_W-1:0]   end_address,
   input  logic [BLK_W-1:0]   block_address,
   data_stream_tx_if.master   bus,
   output logic               Done,
   output logic               busy,
   output logic [CNT_W-1:0]   bytes_left
);

`ifdef DATA_TX_CHECKSUM_EN
   localparam logic [CNT_W-1:0] EXTRA_BYTES    = CNT_W'(1);
`else
   localparam logic [CNT_W-1:0] EXTRA_BYTES    = CNT_W'(0);
`endif
   // bytes_left value while the final data byte is on offer
   localparam logic [CNT_W-1:0] LAST_DATA_LEFT = EXTRA_BYTES + CNT_W'(1);

   tx_state_t         state_reg;
   logic [OFS_W-1:0]  ofs_reg;
   logic [BLK_W-1:0]  blk_reg;
   logic              mem_read_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] tx_data_reg;
   logic              tx_valid_reg;
   logic              done_reg;
   logic              busy_reg;
   logic [CNT_W-1:0]  bytes_left_reg;
`ifdef DATA_TX_CHECKSUM_EN
   logic [DATA_W-1:0] csum_reg;
`endif

   logic [OFS_W-1:0]  ofs_inc;
   logic              timer_load;
   logic              timer_expire;

   assign ofs_inc    = ofs_reg + 1'b1;
   assign timer_load = (state_reg == ISSUE);

   rd_latency_timer #(
      .MEM_LATENCY (MEM_LATENCY)
   ) u_timer (
      .clk     (clk),
      .n_reset (n_reset),
      .load    (timer_load),
      .expire  (timer_expire)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_reg      <= IDLE;
         ofs_reg        <= '0;
         blk_reg        <= '0;
         mem_read_reg   <= 1'b0;
         mem_addr_reg   <= '0;
         tx_data_reg    <= '0;
         tx_valid_reg   <= 1'b0;
         done_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         bytes_left_reg <= '0;
`ifdef DATA_TX_CHECKSUM_EN
         csum_reg       <= '0;
`endif
      end else if (Abort) begin
         // Cancel without completion: no Done, nothing on offer.
         state_reg      <= IDLE;
         mem_read_reg   <= 1'b0;
         tx_valid_reg   <= 1'b0;
         done_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         bytes_left_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (StartEnable) begin
                  ofs_reg        <= start_address;
                  blk_reg        <= block_address;
                  bytes_left_reg <= byte_count(start_address, end_address) + EXTRA_BYTES;
                  mem_read_reg   <= 1'b1;
                  mem_addr_reg   <= {block_address, start_address};
                  busy_reg       <= 1'b1;
`ifdef DATA_TX_CHECKSUM_EN
                  csum_reg       <= '0;
`endif
                  state_reg      <= ISSUE;
               end
            end

            ISSUE: begin
               mem_read_reg <= 1'b0;
               state_reg    <= WAIT;
            end

            WAIT: begin
               if (timer_expire) begin
                  tx_data_reg  <= bus.mem_rdata;
                  tx_valid_reg <= 1'b1;
                  state_reg    <= SEND;
               end
            end

            SEND: begin
               if (bus.tx_ready) begin
                  ofs_reg        <= ofs_inc;
                  bytes_left_reg <= bytes_left_reg - 1'b1;
`ifdef DATA_TX_CHECKSUM_EN
                  csum_reg       <= csum_reg ^ tx_data_reg;
`endif
                  if (bytes_left_reg == LAST_DATA_LEFT) begin
`ifdef DATA_TX_CHECKSUM_EN
                     // tx_valid stays high: the checksum follows back to back.
                     tx_data_reg  <= csum_reg ^ tx_data_reg;
                     state_reg    <= CSUM;
`else
                     tx_valid_reg <= 1'b0;
                     done_reg     <= 1'b1;
                     state_reg    <= DONE;
`endif
                  end else begin
                     tx_valid_reg <= 1'b0;
                     mem_read_reg <= 1'b1;
                     mem_addr_reg <= {blk_reg, ofs_inc};
                     state_reg    <= ISSUE;
                  end
               end
            end

`ifdef DATA_TX_CHECKSUM_EN
            CSUM: begin
               if (bus.tx_ready) begin
                  tx_valid_reg   <= 1'b0;
                  bytes_left_reg <= '0;
                  done_reg       <= 1'b1;
                  state_reg      <= DONE;
               end
            end
`endif

            DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg    <= IDLE;
               mem_read_reg <= 1'b0;
               tx_valid_reg <= 1'b0;
               done_reg     <= 1'b0;
               busy_reg     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_read = mem_read_reg;
   assign bus.mem_addr = mem_addr_reg;
   assign bus.tx_data  = tx_data_reg;
   assign bus.tx_valid = tx_valid_reg;
   assign Done         = done_reg;
   assign busy         = busy_reg;
   assign bytes_left   = bytes_left_reg;

endmodule

// File: tb/tb_data_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_data_stream_tx
// Bench for data_stream_tx: a fixed-latency memory model, a transmitter with
// selectable ready behaviour, and a reference that derives the expected
// address/byte stream from the offset range with plain modular arithmetic.
// -----------------------------------------------------------------------------
module tb_data_stream_tx;
   import data_tx_pkg::*;

   localparam int MEM_LAT  = 2;
   localparam int CLK_HALF = 5;
`ifdef DATA_TX_CHECKSUM_EN
   localparam int CS_BYTES = 1;
`else
   localparam int CS_BYTES = 0;
`endif

   logic              clk = 1'b0;
   logic              n_reset;
   logic              StartEnable;
   logic              Abort;
   logic [OFS_W-1:0]  start_address;
   logic [OFS_W-1:0]  end_address;
   logic [BLK_W-1:0]  block_address;
   logic              Done;
   logic              busy;
   logic [CNT_W-1:0]  bytes_left;

   data_stream_tx_if bus_if();

   data_stream_tx #(.MEM_LATENCY(MEM_LAT)) dut (
      .clk           (clk),
      .n_reset       (n_reset),
      .StartEnable   (StartEnable),
      .Abort         (Abort),
      .start_address (start_address),
      .end_address   (end_address),
      .block_address (block_address),
      .bus           (bus_if),
      .Done          (Done),
      .busy          (busy),
      .bytes_left    (bytes_left)
   );

   always #CLK_HALF clk = ~clk;

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- memory model ----------------
   logic [7:0]  mem [0:65535];
   logic        pipe_vld  [MEM_LAT];
   logic [15:0] pipe_addr [MEM_LAT];
   logic [7:0]  junk;

   always @(posedge clk) begin
      if (!n_reset) begin
         for (int i = 0; i < MEM_LAT; i++) pipe_vld[i] <= 1'b0;
      end else begin
         pipe_vld[0]  <= bus_if.mem_read;
         pipe_addr[0] <= bus_if.mem_addr;
         for (int i = 1; i < MEM_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
         end
      end
      junk <= 8'($urandom);
   end

   // Data is only meaningful in the cycle MEM_LAT after the strobe.
   assign bus_if.mem_rdata = pipe_vld[MEM_LAT-1] ? mem[pipe_addr[MEM_LAT-1]] : junk;

   // ---------------- cycle counter / monitor ----------------
   int          cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] mon_addr [$];
   logic [7:0]  mon_data [$];
   int          done_cnt, done_cyc, last_xfer_cyc, first_valid_cyc;
   int          xfer_cnt, stall_cnt, exp_total, first_bl;
   bit          seen_valid;
   bit          stab_en = 1'b1;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h0;
   int          rdy_mode = 0;

   always @(negedge clk) begin
      if (stab_en && prev_stall) begin
         check("hold_valid", 32'(bus_if.tx_valid), 32'd1);
         check("hold_data", 32'(bus_if.tx_data), 32'(prev_data));
      end
      prev_stall = bus_if.tx_valid && !bus_if.tx_ready;
      prev_data  = bus_if.tx_data;
      if (bus_if.mem_read) begin
         if (mon_addr.size() == 0) first_bl = int'(bytes_left);
         mon_addr.push_back(bus_if.mem_addr);
      end
      if (bus_if.tx_valid && !seen_valid) begin
         seen_valid      = 1'b1;
         first_valid_cyc = cyc;
      end
      if (bus_if.tx_valid && !bus_if.tx_ready && xfer_cnt == 1) stall_cnt++;
      if (bus_if.tx_valid && bus_if.tx_ready) begin
         check("bytes_left_at_xfer", 32'(bytes_left), 32'(exp_total - xfer_cnt));
         mon_data.push_back(bus_if.tx_data);
         xfer_cnt++;
         last_xfer_cyc = cyc;
      end
      if (Done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   // ---------------- transmitter ready driver ----------------
   initial begin
      bus_if.tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus_if.tx_ready = 1'b1;
            1:       bus_if.tx_ready = ($urandom_range(0, 99) < 70);
            2:       bus_if.tx_ready = !(xfer_cnt == 1 && stall_cnt < 5);
            default: bus_if.tx_ready = 1'b0;
         endcase
      end
   end

   task automatic mon_clear(input int total, input int mode);
      mon_addr.delete();
      mon_data.delete();
      done_cnt   = 0;
      xfer_cnt   = 0;
      stall_cnt  = 0;
      seen_valid = 1'b0;
      first_bl   = -1;
      exp_total  = total;
      rdy_mode   = mode;
   endtask

   task automatic launch(input logic [5:0] s, input logic [5:0] e, input logic [9:0] b,
                         output int se_cyc);
      @(posedge clk);
      #1;
      start_address = s;
      end_address   = e;
      block_address = b;
      StartEnable   = 1'b1;
      se_cyc        = cyc;
      @(posedge clk);
      #1;
      StartEnable   = 1'b0;
   endtask

   // Full transaction against the reference stream.
   task automatic run_txn(input logic [5:0] s, input logic [5:0] e, input logic [9:0] b,
                          input int mode);
      logic [5:0]  span;
      logic [5:0]  o;
      logic [15:0] exp_a [$];
      logic [7:0]  exp_b [$];
      logic [7:0]  x;
      int          cnt, total, tout, se_cyc;
      span = e - s;
      cnt  = int'(span) + 1;
      x    = 8'h00;
      for (int i = 0; i < cnt; i++) begin
         o = 6'((int'(s) + i) % 64);
         exp_a.push_back({b, o});
         exp_b.push_back(mem[{b, o}]);
         x = x ^ mem[{b, o}];
      end
      if (CS_BYTES == 1) exp_b.push_back(x);
      total = exp_b.size();
      mon_clear(total, mode);
      launch(s, e, b, se_cyc);
      tout = 0;
      while (done_cnt == 0 && tout < 3000) begin
         @(posedge clk);
         tout++;
      end
      check("done_timeout", 32'(tout < 3000), 32'd1);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(Done), 32'd0);
      check("idle_bytes_left", 32'(bytes_left), 32'd0);
      check("idle_tx_valid", 32'(bus_if.tx_valid), 32'd0);
      check("n_reads", 32'(mon_addr.size()), 32'(cnt));
      for (int i = 0; i < cnt && i < mon_addr.size(); i++)
         check($sformatf("addr[%0d]", i), 32'(mon_addr[i]), 32'(exp_a[i]));
      check("n_bytes", 32'(mon_data.size()), 32'(total));
      for (int i = 0; i < total && i < mon_data.size(); i++)
         check($sformatf("byte[%0d]", i), 32'(mon_data[i]), 32'(exp_b[i]));
      check("bytes_left_start", 32'(first_bl), 32'(total));
      check("first_valid_lat", 32'(first_valid_cyc - se_cyc), 32'(MEM_LAT + 2));
      check("done_after_last", 32'(done_cyc - last_xfer_cyc), 32'd1);
      repeat (3) @(negedge clk);
      check("done_once", 32'(done_cnt), 32'd1);
      $display("[TB] txn start=%0d end=%0d blk=0x%0h mode=%0d bytes=%0d", s, e, b, mode, mon_data.size());
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #(2 * CLK_HALF * 80000);
      $display("FAIL watchdog: got no finish, expected finish within 80000 cycles");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int tout;
      int se_cyc;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      n_reset       = 1'b0;
      StartEnable   = 1'b0;
      Abort         = 1'b0;
      start_address = '0;
      end_address   = '0;
      block_address = '0;

      // Reset state
      @(posedge clk);
      #1;
      check("rst_mem_read", 32'(bus_if.mem_read), 32'd0);
      check("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
      check("rst_tx_data", 32'(bus_if.tx_data), 32'd0);
      check("rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bytes_left", 32'(bytes_left), 32'd0);
      @(posedge clk);
      #1;
      n_reset = 1'b1;

      // 1: basic 4-byte run
      run_txn(6'd5, 6'd8, 10'h2A3, 0);
      check("t1_first_addr", 32'(mon_addr.size() > 0 ? mon_addr[0] : 16'h0), 32'hA8C5);
      check("t1_last_addr", 32'(mon_addr.size() > 3 ? mon_addr[3] : 16'h0), 32'hA8C8);

      // 2: wrap through offset 63
      run_txn(6'd62, 6'd1, 10'h011, 0);
      check("t2_wrap_addr", 32'(mon_addr.size() > 2 ? mon_addr[2] : 16'h0), 32'h0440);

      // 3: single byte and full block
      run_txn(6'h10, 6'h10, 10'h3FF, 0);
      run_txn(6'd0, 6'd63, 10'h100, 0);

      // 4: transmitter stalls 5 cycles on byte 2
      run_txn(6'd20, 6'd24, 10'h07C, 2);
      check("t4_stall_cycles", 32'(stall_cnt), 32'd5);

      // 6: checksum pattern
      mem[{10'h155, 6'd3}] = 8'h12;
      mem[{10'h155, 6'd4}] = 8'h34;
      mem[{10'h155, 6'd5}] = 8'hFF;
      run_txn(6'd3, 6'd5, 10'h155, 0);
      check("t6_n_bytes", 32'(mon_data.size()), 32'(3 + CS_BYTES));
      if (CS_BYTES == 1)
         check("t6_csum", 32'(mon_data.size() > 3 ? mon_data[3] : 8'h0), 32'hD9);

      // 5a: Abort during WAIT of byte 3
      stab_en = 1'b0;
      mon_clear(11 + CS_BYTES, 0);
      launch(6'd0, 6'd10, 10'h222, se_cyc);
      tout = 0;
      while (mon_addr.size() < 3 && tout < 100) begin
         @(negedge clk);
         tout++;
      end
      check("abort_reach_byte3", 32'(tout < 100), 32'd1);
      @(posedge clk);
      #1;
      Abort = 1'b1;
      @(posedge clk);
      #1;
      Abort = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_tx_valid", 32'(bus_if.tx_valid), 32'd0);
      check("abort_mem_read", 32'(bus_if.mem_read), 32'd0);
      check("abort_bytes_left", 32'(bytes_left), 32'd0);
      repeat (10) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_no_more_reads", 32'(mon_addr.size()), 32'd3);
      $display("[TB] abort in WAIT of byte 3, bytes sent=%0d", mon_data.size());

      // 5b: asynchronous reset while a byte is on offer
      mon_clear(8 + CS_BYTES, 3);
      launch(6'd40, 6'd47, 10'h0AA, se_cyc);
      tout = 0;
      while (!bus_if.tx_valid && tout < 50) begin
         @(negedge clk);
         tout++;
      end
      check("rst_reach_send", 32'(tout < 50), 32'd1);
      #1;
      n_reset = 1'b0;
      #1;
      check("arst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
      check("arst_tx_data", 32'(bus_if.tx_data), 32'd0);
      check("arst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_bytes_left", 32'(bytes_left), 32'd0);
      @(posedge clk);
      #1;
      n_reset = 1'b1;
      repeat (6) @(negedge clk);
      check("arst_no_resume_valid", 32'(bus_if.tx_valid), 32'd0);
      check("arst_no_resume_busy", 32'(busy), 32'd0);
      check("arst_no_done", 32'(done_cnt), 32'd0);
      $display("[TB] async reset mid-SEND, outputs cleared");
      stab_en = 1'b1;

      // Randomized runs
      for (int t = 0; t < 16; t++) begin
         run_txn(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                 10'($urandom_range(0, 1023)), int'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
